// File: rtl/mem_requester.sv
// mem_requester: client-side endpoint of the memory-controller FIFO protocol with an out-of-order TID scoreboard.
// Optional watchdog: define MEM_REQUESTER_WATCHDOG_EN to enable the timeout_err counter.
module mem_requester #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 31,
  parameter int TID_WIDTH       = 16,
  parameter int MAX_OUTSTANDING = 8,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    req_valid,
  output logic                                    req_ready,
  input  logic                                    req_rw,
  input  logic [ADDR_WIDTH-1:0]                   req_addr,
  input  logic [DATA_WIDTH-1:0]                   req_data,
  output logic                                    write_ctr,
  output logic [TID_WIDTH+ADDR_WIDTH+DATA_WIDTH:0] data_out,
  input  logic                                    full_flag,
  output logic                                    read_ctr,
  input  logic [TID_WIDTH+DATA_WIDTH-1:0]         data_in,
  input  logic                                    empty_flag,
  output logic                                    rsp_valid,
  output logic [TID_WIDTH-1:0]                    rsp_tid,
  output logic                                    rsp_rw,
  output logic [DATA_WIDTH-1:0]                   rsp_data,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]    outstanding,
  output logic                                    err_unexpected,
  output logic                                    timeout_err
);

  localparam int SLOT_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  if (MAX_OUTSTANDING < 2 || (MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0 ||
      TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("mem_requester: MAX_OUTSTANDING must be a power of 2 >= 2 and TIMEOUT_CYCLES >= 1");
  end

  logic [MAX_OUTSTANDING-1:0] busy;
  logic [MAX_OUTSTANDING-1:0] slot_rw;
  logic [TID_WIDTH-1:0]       slot_tid [MAX_OUTSTANDING];
  logic [TID_WIDTH-1:0]       next_tid;
  logic                       pop_d;

  logic [SLOT_W-1:0]     issue_slot;
  logic [SLOT_W-1:0]     rsp_slot;
  logic [TID_WIDTH-1:0]  in_tid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  issue;
  logic                  hit;
  logic                  retire;

  // A TID owns slot TID mod MAX_OUTSTANDING, so issue also stalls while that slot is still busy.
  assign issue_slot = next_tid[SLOT_W-1:0];
  assign req_ready  = !reset && !full_flag && (outstanding < MAX_CNT) && !busy[issue_slot];
  assign write_ctr  = req_valid && req_ready;
  assign issue      = write_ctr;
  assign data_out   = {next_tid, req_rw, req_addr, req_data};

  assign read_ctr = !reset && !empty_flag;
  assign in_tid   = data_in[TID_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
  assign in_data  = data_in[DATA_WIDTH-1:0];
  assign rsp_slot = in_tid[SLOT_W-1:0];
  assign hit      = busy[rsp_slot] && (slot_tid[rsp_slot] == in_tid);
  assign retire   = pop_d && hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= '0;
      slot_rw  <= '0;
      next_tid <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        slot_tid[i] <= '0;
      end
    end else begin
      if (retire) begin
        busy[rsp_slot] <= 1'b0;
      end
      if (issue) begin
        busy[issue_slot]     <= 1'b1;
        slot_tid[issue_slot] <= next_tid;
        slot_rw[issue_slot]  <= req_rw;
        next_tid             <= next_tid + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding <= '0;
    end else if (issue && !retire) begin
      outstanding <= outstanding + 1'b1;
    end else if (retire && !issue) begin
      outstanding <= outstanding - 1'b1;
    end
  end

  // Unmatched words are dropped; only the sticky error flag records them.
  always_ff @(posedge clk) begin
    if (reset) begin
      pop_d          <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_tid        <= '0;
      rsp_rw         <= 1'b0;
      rsp_data       <= '0;
      err_unexpected <= 1'b0;
    end else begin
      pop_d     <= read_ctr;
      rsp_valid <= retire;
      if (retire) begin
        rsp_tid  <= in_tid;
        rsp_rw   <= slot_rw[rsp_slot];
        rsp_data <= in_data;
      end
      if (pop_d && !hit) begin
        err_unexpected <= 1'b1;
      end
    end
  end

`ifdef MEM_REQUESTER_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt;

  // Counts cycles of no progress while work is in flight; saturates at the limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else if (retire || outstanding == '0) begin
      wd_cnt <= '0;
    end else if (wd_cnt != WD_LIMIT) begin
      wd_cnt <= wd_cnt + 1'b1;
      if (wd_cnt == WD_LAST) begin
        timeout_err <= 1'b1;
      end
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_requester.sv
// Self-checking bench for mem_requester: directed protocol scenarios plus a randomized run
// against a queue-based model of the scoreboard and a toy out-of-order memory controller.
module tb_mem_requester;

  localparam int DW   = 32;
  localparam int AW   = 31;
  localparam int TW   = 16;
  localparam int MAXO = 8;
  localparam int TO   = 16;

  typedef struct { logic [TW-1:0] tid; logic rw; } txn_t;
  typedef struct { logic [TW-1:0] tid; logic [DW-1:0] data; } rsp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_rw;
  logic [AW-1:0]     req_addr;
  logic [DW-1:0]     req_data;
  logic              write_ctr;
  logic [TW+AW+DW:0] data_out;
  logic              full_flag;
  logic              read_ctr;
  logic [TW+DW-1:0]  data_in;
  logic              empty_flag;
  logic              rsp_valid;
  logic [TW-1:0]     rsp_tid;
  logic              rsp_rw;
  logic [DW-1:0]     rsp_data;
  logic [3:0]        outstanding;
  logic              err_unexpected;
  logic              timeout_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_requester #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TID_WIDTH(TW),
    .MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_data(req_data),
    .write_ctr(write_ctr), .data_out(data_out), .full_flag(full_flag),
    .read_ctr(read_ctr), .data_in(data_in), .empty_flag(empty_flag),
    .rsp_valid(rsp_valid), .rsp_tid(rsp_tid), .rsp_rw(rsp_rw), .rsp_data(rsp_data),
    .outstanding(outstanding), .err_unexpected(err_unexpected), .timeout_err(timeout_err)
  );

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = 1'b0; full_flag = 1'b0; empty_flag = 1'b1; data_in = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b1; req_rw = 1'b1; req_addr = '1; req_data = '1;
    full_flag = 1'b0; empty_flag = 1'b0; data_in = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({req_ready, write_ctr, read_ctr, rsp_valid, err_unexpected, timeout_err} !== 6'b0) begin
        errors++;
        $display("[TB] FAIL reset_ctl got %b exp 000000", {req_ready, write_ctr, read_ctr, rsp_valid, err_unexpected, timeout_err});
      end
      checks++;
      if ({outstanding, rsp_tid, rsp_rw, rsp_data} !== '0) begin
        errors++;
        $display("[TB] FAIL reset_regs got out=%0d tid=%h rw=%b data=%h exp all 0", outstanding, rsp_tid, rsp_rw, rsp_data);
      end
      tick();
    end
    reset = 1'b0; req_valid = 1'b0; empty_flag = 1'b1; data_in = {16'h00FF, 32'hDEAD_BEEF};
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_release_ready got %b exp 1", req_ready);
    end
    tick();
    data_in = '0;
    @(negedge clk);
    checks++;
    if (err_unexpected !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL post_reset_word err=%b rsp_valid=%b exp 0 0", err_unexpected, rsp_valid);
    end
    tick();
  endtask

  task automatic test_single_write();
    do_reset();
    req_valid = 1'b1; req_rw = 1'b1; req_addr = 31'h10; req_data = 32'd15;
    @(negedge clk);
    checks++;
    if (write_ctr !== 1'b1) begin
      errors++; $display("[TB] FAIL single_write_ctr got %b exp 1", write_ctr);
    end
    checks++;
    if (data_out !== {16'h0000, 1'b1, 31'h10, 32'd15}) begin
      errors++; $display("[TB] FAIL single_data_out got %h exp %h", data_out, {16'h0000, 1'b1, 31'h10, 32'd15});
    end
    tick();
    req_valid = 1'b0; empty_flag = 1'b0;
    @(negedge clk);
    checks++;
    if (outstanding !== 4'd1 || read_ctr !== 1'b1) begin
      errors++; $display("[TB] FAIL single_issued out=%0d read_ctr=%b exp 1 1", outstanding, read_ctr);
    end
    tick();
    empty_flag = 1'b1; data_in = {16'h0000, 32'h0000_ABCD};
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL single_early_rsp got %b exp 0", rsp_valid);
    end
    tick();
    data_in = '0;
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_tid, rsp_rw, rsp_data, outstanding} !== {1'b1, 16'h0, 1'b1, 32'h0000_ABCD, 4'd0}) begin
      errors++;
      $display("[TB] FAIL single_rsp got v=%b tid=%h rw=%b data=%h out=%0d exp 1 0000 1 0000abcd 0", rsp_valid, rsp_tid, rsp_rw, rsp_data, outstanding);
    end
    tick();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL single_rsp_pulse got %b exp 0", rsp_valid);
    end
    tick();
  endtask

  task automatic test_credit_limit();
    do_reset();
    for (int i = 0; i < MAXO; i++) begin
      req_valid = 1'b1; req_rw = 1'b0; req_addr = AW'(i * 4); req_data = $urandom;
      @(negedge clk);
      checks++;
      if (write_ctr !== 1'b1 || data_out[TW+AW+DW:AW+DW+1] !== TW'(i)) begin
        errors++; $display("[TB] FAIL credit_issue wr=%b tid=%h exp 1 %h", write_ctr, data_out[TW+AW+DW:AW+DW+1], TW'(i));
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0 || write_ctr !== 1'b0 || outstanding !== 4'd8) begin
      errors++; $display("[TB] FAIL credit_stall ready=%b wr=%b out=%0d exp 0 0 8", req_ready, write_ctr, outstanding);
    end
    tick();
  endtask

  // Continues from the credit-limit state: TIDs 0..7 outstanding, client still requesting.
  task automatic test_out_of_order();
    empty_flag = 1'b0;
    @(negedge clk);
    checks++;
    if (read_ctr !== 1'b1 || write_ctr !== 1'b0) begin
      errors++; $display("[TB] FAIL ooo_pop rd=%b wr=%b exp 1 0", read_ctr, write_ctr);
    end
    tick();
    empty_flag = 1'b1; data_in = {16'd3, 32'h0000_3333};
    tick();
    data_in = '0;
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_tid, rsp_rw, rsp_data, outstanding} !== {1'b1, 16'd3, 1'b0, 32'h0000_3333, 4'd7}) begin
      errors++;
      $display("[TB] FAIL ooo_rsp3 got v=%b tid=%h rw=%b data=%h out=%0d exp 1 0003 0 00003333 7", rsp_valid, rsp_tid, rsp_rw, rsp_data, outstanding);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b0 || write_ctr !== 1'b0) begin
        errors++; $display("[TB] FAIL ooo_slot_stall ready=%b wr=%b exp 0 0", req_ready, write_ctr);
      end
      tick();
    end
    empty_flag = 1'b0;
    tick();
    data_in = {16'd0, 32'h0000_0A0A};
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL ooo_stall_until_retire got %b exp 0", req_ready);
    end
    tick();
    empty_flag = 1'b1; data_in = {16'd1, 32'h0000_1111};
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_tid, rsp_data, outstanding} !== {1'b1, 16'd0, 32'h0000_0A0A, 4'd6}) begin
      errors++; $display("[TB] FAIL ooo_rsp0 got v=%b tid=%h data=%h out=%0d exp 1 0000 00000a0a 6", rsp_valid, rsp_tid, rsp_data, outstanding);
    end
    checks++;
    if (write_ctr !== 1'b1 || data_out[TW+AW+DW:AW+DW+1] !== 16'd8) begin
      errors++; $display("[TB] FAIL ooo_tid8_issue wr=%b tid=%h exp 1 0008", write_ctr, data_out[TW+AW+DW:AW+DW+1]);
    end
    tick();
    req_valid = 1'b0; data_in = '0;
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_tid, outstanding} !== {1'b1, 16'd1, 4'd6}) begin
      errors++; $display("[TB] FAIL ooo_issue_and_retire got v=%b tid=%h out=%0d exp 1 0001 6", rsp_valid, rsp_tid, outstanding);
    end
    tick();
  endtask

  task automatic test_full_flag();
    do_reset();
    full_flag = 1'b1; req_valid = 1'b1; req_rw = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0 || write_ctr !== 1'b0) begin
      errors++; $display("[TB] FAIL full_block ready=%b wr=%b exp 0 0", req_ready, write_ctr);
    end
    tick();
    full_flag = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || write_ctr !== 1'b1) begin
      errors++; $display("[TB] FAIL full_release ready=%b wr=%b exp 1 1", req_ready, write_ctr);
    end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_unexpected();
    do_reset();
    empty_flag = 1'b0;
    tick();
    empty_flag = 1'b1; data_in = {16'h00FF, 32'h1234_5678};
    @(negedge clk);
    checks++;
    if (err_unexpected !== 1'b0) begin
      errors++; $display("[TB] FAIL unexp_initial got %b exp 0", err_unexpected);
    end
    tick();
    data_in = '0;
    @(negedge clk);
    checks++;
    if ({err_unexpected, rsp_valid, outstanding} !== {1'b1, 1'b0, 4'd0}) begin
      errors++; $display("[TB] FAIL unexp_idle err=%b v=%b out=%0d exp 1 0 0", err_unexpected, rsp_valid, outstanding);
    end
    tick();
    do_reset();
    req_valid = 1'b1; req_rw = 1'b1;
    tick();
    req_valid = 1'b0; empty_flag = 1'b0;
    tick();
    empty_flag = 1'b1; data_in = {16'h0008, 32'h5555_AAAA};
    tick();
    data_in = '0;
    @(negedge clk);
    checks++;
    if ({err_unexpected, rsp_valid, outstanding} !== {1'b1, 1'b0, 4'd1}) begin
      errors++; $display("[TB] FAIL unexp_alias err=%b v=%b out=%0d exp 1 0 1", err_unexpected, rsp_valid, outstanding);
    end
    tick();
  endtask

  task automatic test_watchdog();
    do_reset();
    req_valid = 1'b1; req_rw = 1'b0;
    tick();
    req_valid = 1'b0;
`ifdef MEM_REQUESTER_WATCHDOG_EN
    repeat (TO - 1) tick();
    @(negedge clk);
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++; $display("[TB] FAIL wd_early got %b exp 0", timeout_err);
    end
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++; $display("[TB] FAIL wd_fire got %b exp 1", timeout_err);
    end
`else
    repeat (3 * TO) tick();
    @(negedge clk);
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++; $display("[TB] FAIL wd_disabled got %b exp 0", timeout_err);
    end
`endif
    tick();
  endtask

  task automatic test_random();
    txn_t out_q[$];
    txn_t ctrl_q[$];
    rsp_t rsp_fifo[$];
    logic [TW-1:0] m_tid;
    rsp_t pop_word;
    bit pop_pend, cur_pop, exp_v, exp_ready, collide;
    logic [TW-1:0] exp_tid;
    logic exp_rw;
    logic [DW-1:0] exp_data;
    int idx;
    m_tid = '0; pop_pend = 0; exp_v = 0; exp_tid = '0; exp_rw = 0; exp_data = '0;
    pop_word = '{tid: '0, data: '0};
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      cur_pop    = pop_pend;
      data_in    = pop_pend ? {pop_word.tid, pop_word.data} : {16'hFFFF, 32'($urandom)};
      empty_flag = (rsp_fifo.size() == 0) || ($urandom_range(0, 3) == 0);
      full_flag  = ($urandom_range(0, 7) == 0);
      req_valid  = ($urandom_range(0, 3) != 0);
      req_rw     = 1'($urandom_range(0, 1));
      req_addr   = AW'($urandom);
      req_data   = $urandom;
      collide = 0;
      foreach (out_q[k]) if (out_q[k].tid % MAXO == m_tid % MAXO) collide = 1;
      exp_ready = !full_flag && (out_q.size() < MAXO) && !collide;
      @(negedge clk);
      checks++;
      if (req_ready !== exp_ready || write_ctr !== (req_valid && exp_ready)) begin
        errors++; $display("[TB] FAIL rnd_handshake cyc=%0d ready=%b wr=%b exp %b %b", cyc, req_ready, write_ctr, exp_ready, req_valid && exp_ready);
      end
      if (req_valid && exp_ready) begin
        checks++;
        if (data_out !== {m_tid, req_rw, req_addr, req_data}) begin
          errors++; $display("[TB] FAIL rnd_data_out cyc=%0d got %h exp %h", cyc, data_out, {m_tid, req_rw, req_addr, req_data});
        end
      end
      checks++;
      if (read_ctr !== !empty_flag) begin
        errors++; $display("[TB] FAIL rnd_read_ctr cyc=%0d got %b exp %b", cyc, read_ctr, !empty_flag);
      end
      checks++;
      if (rsp_valid !== exp_v) begin
        errors++; $display("[TB] FAIL rnd_rsp_valid cyc=%0d got %b exp %b", cyc, rsp_valid, exp_v);
      end
      if (exp_v) begin
        checks++;
        if ({rsp_tid, rsp_rw, rsp_data} !== {exp_tid, exp_rw, exp_data}) begin
          errors++; $display("[TB] FAIL rnd_rsp cyc=%0d got %h %b %h exp %h %b %h", cyc, rsp_tid, rsp_rw, rsp_data, exp_tid, exp_rw, exp_data);
        end
      end
      checks++;
      if (outstanding !== 4'(out_q.size())) begin
        errors++; $display("[TB] FAIL rnd_outstanding cyc=%0d got %0d exp %0d", cyc, outstanding, out_q.size());
      end
      exp_v = 0;
      if (cur_pop) begin
        idx = -1;
        foreach (out_q[k]) if (out_q[k].tid == pop_word.tid) idx = k;
        if (idx >= 0) begin
          exp_v = 1; exp_tid = pop_word.tid; exp_rw = out_q[idx].rw; exp_data = pop_word.data;
          out_q.delete(idx);
        end
      end
      if (req_valid && exp_ready) begin
        out_q.push_back('{tid: m_tid, rw: req_rw});
        ctrl_q.push_back('{tid: m_tid, rw: req_rw});
        m_tid++;
      end
      if (!empty_flag) begin
        pop_word = rsp_fifo.pop_front();
        pop_pend = 1;
      end else begin
        pop_pend = 0;
      end
      if (ctrl_q.size() > 0 && $urandom_range(0, 1) == 1) begin
        idx = $urandom_range(0, ctrl_q.size() - 1);
        rsp_fifo.push_back('{tid: ctrl_q[idx].tid, data: $urandom});
        ctrl_q.delete(idx);
      end
      tick();
    end
    req_valid = 1'b0; empty_flag = 1'b1; full_flag = 1'b0;
    @(negedge clk);
    checks++;
    if (err_unexpected !== 1'b0) begin
      errors++; $display("[TB] FAIL rnd_no_unexpected got %b exp 0", err_unexpected);
    end
    tick();
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_addr = '0; req_data = '0;
    full_flag = 1'b0; empty_flag = 1'b1; data_in = '0;
    tick();
    test_reset();
    test_single_write();
    test_credit_limit();
    test_out_of_order();
    test_full_flag();
    test_unexpected();
    test_watchdog();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] simulation time limit exceeded");
  end

endmodule

// File: doc/mem_requester.md
# mem_requester

Requester-side endpoint of the memory-controller FIFO protocol. It accepts read/write requests from a datapath client and assigns each one a sequential transaction ID (TID). It pushes requests into the request FIFO that a `mem_controller` drains, then pops that controller's response FIFO. Each response is matched against an outstanding-transaction scoreboard and returned to the client, in any completion order.

## Interface
Parameters:
- `DATA_WIDTH`, 32: data field width.
- `ADDR_WIDTH`, 31: address field width.
- `TID_WIDTH`, 16: transaction ID width.
- `MAX_OUTSTANDING`, 8: scoreboard slots. Must be a power of 2 and ≤ 2^TID_WIDTH.
- `TIMEOUT_CYCLES`, 1024: watchdog limit. Used only with the watchdog macro.
- Derived: `REQ_WIDTH` = 1+ADDR_WIDTH+DATA_WIDTH; `DP_DATA_WIDTH` = TID_WIDTH+REQ_WIDTH; `VPI_DATA_WIDTH` = TID_WIDTH+DATA_WIDTH; `SLOT_W` = log2(MAX_OUTSTANDING); `CNT_W` = clog2(MAX_OUTSTANDING+1).

Ports:
- `clk` in 1: single clock, all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: client request present.
- `req_ready` out 1: request accepted this cycle when high together with `req_valid`.
- `req_rw` in 1: 1 = write, 0 = read.
- `req_addr` in ADDR_WIDTH: request address.
- `req_data` in DATA_WIDTH: write data; don't-care for reads.
- `write_ctr` out 1: wr_en of the request FIFO.
- `data_out` out DP_DATA_WIDTH: request word {TID, rw, addr, data}. TID is in the MSBs; rw is at bit REQ_WIDTH-1.
- `full_flag` in 1: request FIFO full.
- `read_ctr` out 1: rd_en of the response FIFO.
- `data_in` in VPI_DATA_WIDTH: response word {TID, data}. Valid the cycle after `read_ctr`.
- `empty_flag` in 1: response FIFO empty.
- `rsp_valid` out 1: one-cycle response pulse. No backpressure.
- `rsp_tid` out TID_WIDTH: TID of the retired transaction.
- `rsp_rw` out 1: rw of the retired transaction, taken from the scoreboard.
- `rsp_data` out DATA_WIDTH: response data.
- `outstanding` out CNT_W: number of busy slots.
- `err_unexpected` out 1: sticky; a response TID did not match any outstanding transaction.
- `timeout_err` out 1: sticky watchdog flag.

## Operation
- **Issue.**
  - `req_ready` = !reset & !full_flag & (outstanding < MAX_OUTSTANDING) & !busy[next_tid[SLOT_W-1:0]].
  - `write_ctr` = req_valid & req_ready, combinational.
  - `data_out` = {next_tid, req_rw, req_addr, req_data}, combinational.
  - On an issue edge: the slot stores the full TID and rw and is set busy; `next_tid` increments and wraps modulo 2^TID_WIDTH; `outstanding` increments.
- **Slot-collision stall.** Completion is out of order, so the next TID's slot can still be busy while `outstanding` < MAX. Issue stalls until that slot retires.
- **Pop.**
  - `read_ctr` = !reset & !empty_flag, giving one pop per cycle.
  - A registered flag `pop_d` marks that `data_in` is valid in the current cycle.
- **Retire (cycle with pop_d=1).**
  - The slot is taken from TID[SLOT_W-1:0] of `data_in`.
  - Match: slot busy and stored TID equals the full TID. On the clock edge: clear busy, decrement `outstanding`, register `rsp_*`, and `rsp_valid`=1 in the next cycle.
  - Mismatch: set `err_unexpected`, no `rsp_valid`, no state change. The word is dropped.
- **Simultaneous issue and retire.** Net `outstanding` is unchanged. Same-slot conflict is impossible: issue needs a free slot, retire needs a busy one.
- **Reset.** Outputs, scoreboard, `next_tid`, `pop_d`, error flags and watchdog are all cleared.
  - Reset mid-operation drops in-flight transactions silently.
  - A `data_in` word arriving the cycle after reset is ignored.

## Timing
- Reset values: `req_ready`=0 and `write_ctr`=0 and `read_ctr`=0 during reset. All registered outputs are 0.
- `req_ready` rises in the first cycle after reset deasserts if `full_flag`=0.
- Issue has zero latency: the FIFO write occurs on the same edge the client handshake completes.
- Response latency: `read_ctr` high in cycle N → `data_in` sampled in N+1 → `rsp_valid` high in N+2.
- Throughput: one issue and one retire per cycle, concurrently.

## Configuration
- `MEM_REQUESTER_WATCHDOG_EN` defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) increments each cycle while `outstanding`>0 and no retire occurs.
  - It clears on any retire or when `outstanding`=0.
  - On reaching TIMEOUT_CYCLES it sets `timeout_err`, which stays set until reset. The counter saturates.
- Not defined: the counter is absent and `timeout_err` is tied 0.

## Test plan
- **Reset:** hold `reset` 3 cycles with `full_flag`=0, `empty_flag`=1 → all outputs 0 during reset; `req_ready`=1 in the first cycle after.
- **Single write:** req rw=1, addr=0x10, data=15 → `write_ctr` pulse with `data_out`={16'h0000,1'b1,31'h10,32'd15}. Then present response {TID 0, data 0xABCD} → `rsp_valid` 2 cycles after `read_ctr` with tid=0, rw=1, data=0xABCD; `outstanding` 1→0.
- **Credit limit:** 8 reads with no responses → TIDs 0..7 issued, 9th stalls. Separately, `full_flag`=1 → `req_ready`=0 and `write_ctr`=0.
- **Out-of-order:** after TIDs 0..7, return TID 3 → rsp tid=3, `outstanding`=7. Next request TID 8 (slot 0) stalls until TID 0 retires, then issues. Issue on the same edge as a retire keeps `outstanding` unchanged.
- **Unexpected response:** response TID 0x00FF with nothing outstanding → `err_unexpected`=1, no `rsp_valid`, `outstanding` unchanged. Also TID 0x0008 while slot 0 holds TID 0 → `err_unexpected`=1.
- **Watchdog (macro on, TIMEOUT_CYCLES=16):** 1 outstanding, no response → `timeout_err`=1 after 16 cycles. Macro off → `timeout_err` stays 0.
